// File: rtl/note_seq_ctrl.sv
// Record/playback sequencer that owns the single port of the note RAM: records
// incoming note codes sequentially and replays the stored song in a tempo loop.
module note_seq_ctrl #(
  parameter int NOTE_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int TICK_DIV = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [NOTE_W-1:0] ram_wdata,
  input  logic [NOTE_W-1:0] ram_rdata,
  output logic [NOTE_W-1:0] play_note,
  output logic              play_strobe,
  output logic [ADDR_W:0]   song_len,
  output logic              full,
  output logic [1:0]        mode
);

  typedef enum logic [2:0] {
    IDLE,
    REC,
    PLAY_RD,
    PLAY_LAT,
    PLAY_HOLD
  } state_t;

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TICK_DIV - 3);
  localparam logic [ADDR_W:0]  DEPTH     = (ADDR_W+1)'(1 << ADDR_W);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   rd_next;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [NOTE_W-1:0]   wdata_q, wdata_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                strobe_q, strobe_d;
  logic [ADDR_W:0]     len_q, len_d;

  assign full = (len_q == DEPTH);

  // Read pointer wraps back to the first note once it would reach the song end.
  assign rd_next = (({1'b0, rd_ptr_q} + (ADDR_W+1)'(1)) == len_q)
                   ? '0 : rd_ptr_q + ADDR_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    note_d   = note_q;
    strobe_d = 1'b0;
    len_d    = len_q;

    if (stop) begin
      state_d = IDLE;
      addr_d  = '0;
      note_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          addr_d = '0;
          if (rec_start) begin
            state_d  = REC;
            wr_ptr_d = '0;
            len_d    = '0;
          end else if (play_start && (len_q != '0)) begin
            state_d  = PLAY_RD;
            rd_ptr_d = '0;
          end
        end

        REC: begin
          if (note_valid && !full) begin
            we_d     = 1'b1;
            addr_d   = wr_ptr_q;
            wdata_d  = note_in;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            len_d    = len_q + (ADDR_W+1)'(1);
          end
        end

        PLAY_RD: begin
          state_d = PLAY_LAT;
        end

        // RAM output is valid now: present the new note and restart the tempo count.
        PLAY_LAT: begin
          state_d  = PLAY_HOLD;
          note_d   = ram_rdata;
          strobe_d = 1'b1;
          cnt_d    = '0;
        end

        PLAY_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d  = PLAY_RD;
            rd_ptr_d = rd_next;
            addr_d   = rd_next;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
          addr_d  = '0;
          note_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      note_q   <= '0;
      strobe_q <= 1'b0;
      len_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      note_q   <= note_d;
      strobe_q <= strobe_d;
      len_q    <= len_d;
    end
  end

  assign ram_addr    = addr_q;
  assign ram_we      = we_q;
  assign ram_wdata   = wdata_q;
  assign play_note   = note_q;
  assign play_strobe = strobe_q;
  assign song_len    = len_q;

  always_comb begin
    mode = 2'b00;
    unique case (state_q)
      REC:                         mode = 2'b01;
      PLAY_RD, PLAY_LAT, PLAY_HOLD: mode = 2'b10;
      default:                     mode = 2'b00;
    endcase
  end

endmodule

// File: doc/note_seq_ctrl.md
Name: note_seq_ctrl

Overview:
Record/playback sequencer for the 64-entry note RAM, sharing its single port between a recording path and a playback path.
- Record mode: captures incoming note codes into sequential RAM addresses.
- Play mode: reads the stored song back in a loop, one note per tempo step.
- Sits between the keypad/note decoder and the tone generator.
- Sole master of the RAM address, write-enable and write-data lines.

Parameters:
NOTE_W, 8, width of a note code
ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64
TICK_DIV, 8, clock cycles between consecutive playback strobes; must be >= 4 (bench value 8, board value 25000000)

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
rec_start  in  1  single-cycle pulse: begin recording (erases previous song)
play_start  in  1  single-cycle pulse: begin looped playback
stop  in  1  single-cycle pulse: return to idle
note_valid  in  1  single-cycle pulse qualifying note_in
note_in  in  NOTE_W  note code to record
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  NOTE_W  RAM write data
ram_rdata  in  NOTE_W  RAM read data; synchronous RAM, valid one cycle after ram_addr is presented
play_note  out  NOTE_W  current playback note; 0 = silence
play_strobe  out  1  one-cycle pulse when play_note changes
song_len  out  ADDR_W+1  number of stored notes, 0..64
full  out  1  song_len == 64
mode  out  2  00 idle, 01 record, 10 play

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0, including ram_addr, ram_we, ram_wdata, play_note, play_strobe, song_len, full and mode; write/read pointers 0; tempo counter 0.
- States: IDLE, REC, PLAY_RD, PLAY_LAT, PLAY_HOLD. mode = 10 for all three PLAY_* states.
- Command priority when pulses coincide: stop > rec_start > play_start.
- rec_start and play_start are accepted only in IDLE; in any other state they are ignored.
- stop in any state: next state IDLE, ram_we=0, play_note=0, play_strobe=0. song_len is kept.

IDLE:
- ram_addr=0, ram_we=0.
- rec_start -> REC; write pointer=0, song_len=0.
- play_start with song_len>0 -> PLAY_RD; read pointer=0.
- play_start with song_len=0 is ignored; state stays IDLE.

REC:
- note_valid sampled at edge N with full=0: during the cycle after edge N, ram_we=1, ram_addr=k (write pointer), ram_wdata=note_in as sampled; write pointer becomes k+1 and song_len becomes k+1 after the same edge.
- ram_we is 0 in every other cycle.
- note_valid asserted in consecutive cycles gives consecutive writes with no gaps.
- full asserts when song_len reaches 64 (the write pointer wraps to 0 internally). While full=1, note_valid is ignored: no write, song_len stays 64. State remains REC until stop.

PLAY:
- PLAY_RD: ram_addr=read pointer, ram_we=0 -> PLAY_LAT.
- PLAY_LAT: ram_addr held -> PLAY_HOLD. On that edge, play_note <= ram_rdata and play_strobe=1 for one cycle; tempo counter cleared.
- PLAY_HOLD: count TICK_DIV-3 cycles, then -> PLAY_RD with read pointer+1. If read pointer+1 == song_len, the read pointer wraps to 0.
- Timing: the first play_strobe occurs 3 cycles after play_start is sampled. Consecutive strobes are exactly TICK_DIV cycles apart. The loop is endless until stop.
- song_len=1 loop: same note re-strobed every TICK_DIV cycles.
- ram_we is never asserted outside REC. ram_addr is 0 in IDLE.
- Reset mid-write or mid-playback: outputs clear asynchronously; no partial ram_we pulse continues after reset assertion.

Test Plan:
- Reset then idle: assert reset asynchronously mid-cycle -> all outputs 0 at once, mode=00; play_start pulse -> mode stays 00 (song_len=0).
- Record 3 notes: rec_start, then note_valid with 0x11, 0x22, 0x33 on back-to-back cycles -> ram_we high for 3 consecutive cycles at addr 0,1,2 with those data; song_len=3; stop -> mode=00, song_len=3.
- Playback loop (TICK_DIV=8) after the previous test: play_start -> play_strobe 3 cycles later with play_note=0x11, then 0x22, 0x33, 0x11 at 8-cycle spacing; ram_we stays 0 throughout.
- Fill and overflow: record 66 note_valid pulses (values 0..65) -> exactly 64 writes, addr 63 holds 63, full=1, song_len=64, pulses 65/66 produce no ram_we.
- Command collision: in IDLE, stop+rec_start in the same cycle -> stays IDLE; rec_start+play_start in the same cycle -> REC; rec_start during PLAY -> ignored, playback continues.
- Stop/reset mid-play: stop during PLAY_HOLD -> play_note=0 next cycle, mode=00; reset asserted during a REC write cycle -> ram_we drops immediately, song_len=0.
